// File: rtl/line_window_buffer.sv
// Sliding KxK pixel window over a raster stream, built from K-1 rotating line memories.
// Define LINE_WINDOW_BUFFER_BACKPRESSURE_EN to add i_win_ready output backpressure.
module line_window_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned K      = 3
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic                    i_sof,
    input  logic [DATA_W-1:0]       i_data,
    input  logic                    i_data_valid,
`ifdef LINE_WINDOW_BUFFER_BACKPRESSURE_EN
    input  logic                    i_win_ready,
`endif
    output logic                    o_in_ready,
    output logic [K*K*DATA_W-1:0]   o_win,
    output logic                    o_win_valid,
    output logic                    o_busy
);

    localparam int unsigned NUM_LINES = K - 1;
    localparam int unsigned COL_W     = $clog2(IMG_W);
    localparam int unsigned ROW_W     = $clog2(K);
    localparam int unsigned PTR_W     = $clog2(NUM_LINES);
    localparam int unsigned WIN_W     = K * K * DATA_W;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_WIN   = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_FULL  = ROW_W'(K - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_LINES - 1);
    localparam logic [PTR_W:0]   LINES_EXT = (PTR_W + 1)'(NUM_LINES);

    typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

    state_e            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [PTR_W-1:0]  oldest_q, oldest_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic              win_valid_q, win_valid_d;

    logic              accept;
    logic              process;
    logic              fire;
    logic [COL_W-1:0]  cur_col;
    logic [PTR_W:0]    rd_sum;
    logic [PTR_W-1:0]  rd_idx [NUM_LINES];
    logic [DATA_W-1:0] new_col [K];

    logic [DATA_W-1:0] line_mem [NUM_LINES][IMG_W];

    assign accept  = i_data_valid && o_in_ready;
    // Pixels arriving in IDLE without a start-of-frame marker are dropped entirely.
    assign process = accept && (i_sof || (state_q != StIdle));
    assign cur_col = i_sof ? '0 : col_q;

    // Line read order: oldest stored line first, wrapping around the rotation pointer.
    always_comb begin
        rd_sum = '0;
        for (int unsigned r = 0; r < NUM_LINES; r++) begin
            rd_sum    = {1'b0, oldest_q} + (PTR_W + 1)'(r);
            rd_idx[r] = (rd_sum >= LINES_EXT) ? PTR_W'(rd_sum - LINES_EXT) : PTR_W'(rd_sum);
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < NUM_LINES; r++) begin
            new_col[r] = line_mem[rd_idx[r]][cur_col];
        end
        new_col[K-1] = i_data;
    end

    always_comb begin
        win_d = win_q;
        if (process) begin
            for (int unsigned r = 0; r < K; r++) begin
                for (int unsigned c = 0; c < K - 1; c++) begin
                    win_d[(r*K + c)*DATA_W +: DATA_W] = win_q[(r*K + c + 1)*DATA_W +: DATA_W];
                end
                win_d[(r*K + K - 1)*DATA_W +: DATA_W] = new_col[r];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        oldest_d = oldest_q;
        fire     = 1'b0;
        if (process) begin
            if (i_sof) begin
                state_d = StFill;
                row_d   = '0;
            end
            if (cur_col == COL_LAST) begin
                col_d    = '0;
                oldest_d = (oldest_q == PTR_LAST) ? '0 : oldest_q + PTR_W'(1);
                if (row_d != ROW_FULL) begin
                    row_d = row_d + ROW_W'(1);
                end
            end else begin
                col_d = cur_col + COL_W'(1);
            end
            if ((state_d == StFill) && (row_d == ROW_FULL)) begin
                state_d = StRun;
            end
            // The pixel that completes the fill only arms RUN; its window would mix stale rows.
            fire = (state_q == StRun) && !i_sof && (cur_col >= COL_WIN);
        end
    end

`ifdef LINE_WINDOW_BUFFER_BACKPRESSURE_EN
    always_comb begin
        if (process) begin
            win_valid_d = fire;
        end else begin
            win_valid_d = win_valid_q && !i_win_ready;
        end
    end

    assign o_in_ready = !win_valid_q || i_win_ready;
`else
    always_comb begin
        win_valid_d = fire;
    end

    assign o_in_ready = 1'b1;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            oldest_q    <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            oldest_q    <= oldest_d;
            win_q       <= win_d;
            win_valid_q <= win_valid_d;
        end
    end

    // Line storage needs no reset: every entry is rewritten during FILL before it is used.
    always_ff @(posedge clk) begin
        if (process) begin
            line_mem[oldest_q][cur_col] <= i_data;
        end
    end

    assign o_win       = win_q;
    assign o_win_valid = win_valid_q;
    assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_line_window_buffer.sv
// Self-checking bench for line_window_buffer (IMG_W=8, K=3): directed streams plus random
// traffic, all compared each cycle against a frame-image model of the window.
module tb_line_window_buffer;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 8;
    localparam int K      = 3;
    localparam int WIN_W  = K * K * DATA_W;
`ifdef LINE_WINDOW_BUFFER_BACKPRESSURE_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    localparam logic [WIN_W-1:0] FIRST_WIN  = 72'h12_11_10_0a_09_08_02_01_00;
    localparam logic [WIN_W-1:0] SECOND_WIN = 72'h76_75_74_6e_6d_6c_66_65_64;

    logic              clk = 1'b0;
    logic              rstN;
    logic              i_sof;
    logic              i_data_valid;
    logic [DATA_W-1:0] i_data;
    logic              o_in_ready;
    logic              o_win_valid;
    logic              o_busy;
    logic [WIN_W-1:0]  o_win;
    logic              win_ready;

    line_window_buffer #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .K      (K)
    ) dut (
        .clk          (clk),
        .rstN         (rstN),
        .i_sof        (i_sof),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
`ifdef LINE_WINDOW_BUFFER_BACKPRESSURE_EN
        .i_win_ready  (win_ready),
`endif
        .o_in_ready   (o_in_ready),
        .o_win        (o_win),
        .o_win_valid  (o_win_valid),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    // Model: the frame image since the last start-of-frame, indexed by frame row and column.
    logic [DATA_W-1:0] img [16][IMG_W];
    int                m_row;
    int                m_col;
    bit                armed;
    bit                exp_valid;
    bit                exp_known;
    logic [WIN_W-1:0]  exp_win;

    int total;
    int bad;
    int win_count;
    bit rand_ready;

    task automatic chk(input string name, input logic [WIN_W-1:0] act,
                       input logic [WIN_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        armed     = 1'b0;
        exp_valid = 1'b0;
        exp_known = 1'b1;
        exp_win   = '0;
        m_row     = 0;
        m_col     = 0;
    endfunction

    function automatic void model_update(input bit acc, input bit sof,
                                         input logic [DATA_W-1:0] d);
        if (acc && (sof || armed)) begin
            if (sof) begin
                armed = 1'b1;
                m_row = 0;
                m_col = 0;
            end
            img[m_row % 16][m_col] = d;
            if (m_row >= K - 1 && m_col >= K - 1) begin
                exp_valid = 1'b1;
                exp_known = 1'b1;
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        exp_win[(r*K + c)*DATA_W +: DATA_W] =
                            img[(m_row - (K - 1) + r) % 16][m_col - (K - 1) + c];
                    end
                end
            end else begin
                exp_valid = 1'b0;
                exp_known = 1'b0;
            end
            m_col++;
            if (m_col == IMG_W) begin
                m_col = 0;
                m_row++;
            end
        end else begin
            exp_valid = BP && exp_valid && !win_ready;
        end
    endfunction

    always @(negedge clk) begin
        chk("win_valid", {71'd0, o_win_valid}, {71'd0, exp_valid});
        chk("busy", {71'd0, o_busy}, {71'd0, armed});
        chk("in_ready", {71'd0, o_in_ready}, {71'd0, (BP ? (!exp_valid || win_ready) : 1'b1)});
        if (exp_known) begin
            chk("win", o_win, exp_win);
        end
        if (o_win_valid && (!BP || win_ready)) begin
            win_count++;
        end
    end

    task automatic step(input bit dv, input bit sof, input logic [DATA_W-1:0] d,
                        output bit acc);
        i_data_valid = dv;
        i_sof        = sof;
        i_data       = d;
        if (rand_ready) begin
            win_ready = ($urandom_range(0, 3) != 0);
        end
        acc = dv && (!BP || !exp_valid || win_ready);
        @(posedge clk);
        #1;
        model_update(acc, sof, d);
    endtask

    task automatic send(input bit sof, input logic [DATA_W-1:0] d);
        bit acc;
        int n;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            step(1'b1, sof, d, acc);
            n++;
        end
        if (!acc) begin
            bad++;
            $display("FAIL send_timeout: got no accept, want accept within 100 cycles");
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, '0, acc);
        end
    endtask

    initial begin
        bit acc;
        int c0;
        int c1;
        int p;
        int nrows;
        total        = 0;
        bad          = 0;
        win_count    = 0;
        rand_ready   = 1'b0;
        win_ready    = 1'b1;
        i_sof        = 1'b0;
        i_data_valid = 1'b0;
        i_data       = '0;
        rstN         = 1'b0;
        model_reset();
        #2;
        chk("rst_valid", {71'd0, o_win_valid}, '0);
        chk("rst_win", o_win, '0);
        chk("rst_busy", {71'd0, o_busy}, '0);
        chk("rst_in_ready", {71'd0, o_in_ready}, 72'd1);
        #10;
        rstN = 1'b1;

        // Pixels before any start-of-frame are ignored.
        for (int i = 0; i < 3; i++) send(1'b0, 8'haa);
        chk("idle_busy", {71'd0, o_busy}, '0);

        // Frame A: value = row*8 + col, gap-free.
        c0 = win_count;
        c1 = 0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                send(r == 0 && c == 0, DATA_W'(r * 8 + c));
                if (r == 2 && c == 0) c1 = win_count;
                if (r == 2 && c == 2) chk("first_win", o_win, FIRST_WIN);
                if (r == 3 && c == 1) chk("row2_windows", 72'(win_count - c1), 72'd6);
            end
        end
        idle(2);
        chk("frameA_windows", 72'(win_count - c0), 72'd24);

        // Frame restart: start-of-frame reasserted at pixel (3,4).
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (r < 3 || c < 4) send(r == 0 && c == 0, DATA_W'(r * 8 + c));
            end
        end
        send(1'b1, 8'd100);
        c0 = win_count;
        for (p = 1; p < 4 * IMG_W; p++) begin
            send(1'b0, DATA_W'(100 + p));
            if (p == 2 * IMG_W + 2) begin
                chk("restart_quiet", 72'(win_count - c0), '0);
                chk("restart_first_win", o_win, SECOND_WIN);
            end
        end
        for (int c = 0; c < 6; c++) send(1'b0, DATA_W'($urandom_range(0, 255)));

        // Reset mid-RUN, right after a window was produced.
        i_data_valid = 1'b0;
        rstN = 1'b0;
        #1;
        chk("midrst_valid", {71'd0, o_win_valid}, '0);
        chk("midrst_win", o_win, '0);
        chk("midrst_busy", {71'd0, o_busy}, '0);
        chk("midrst_in_ready", {71'd0, o_in_ready}, 72'd1);
        model_reset();
        #5;
        rstN = 1'b1;
        c0 = win_count;
        for (int i = 0; i < 5; i++) send(1'b0, DATA_W'($urandom_range(0, 255)));
        chk("postrst_busy", {71'd0, o_busy}, '0);
        chk("postrst_windows", 72'(win_count - c0), '0);

        // Frame A again with one idle cycle in every three.
        c0 = win_count;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                send(r == 0 && c == 0, DATA_W'(r * 8 + c));
                if (r == 2 && c == 2) chk("gap_first_win", o_win, FIRST_WIN);
                if ((r * IMG_W + c) % 2 == 1) idle(1);
            end
        end
        idle(2);
        chk("gap_windows", 72'(win_count - c0), 72'd24);

`ifdef LINE_WINDOW_BUFFER_BACKPRESSURE_EN
        // Hold the window consumer off for five cycles with a window pending.
        c0 = win_count;
        for (p = 0; p <= 2 * IMG_W + 2; p++) send(p == 0, DATA_W'(p));
        win_ready = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DATA_W'(2 * IMG_W + 3), acc);
        chk("stall_in_ready", {71'd0, o_in_ready}, '0);
        chk("stall_valid", {71'd0, o_win_valid}, 72'd1);
        chk("stall_win", o_win, FIRST_WIN);
        win_ready = 1'b1;
        for (p = 2 * IMG_W + 3; p < 4 * IMG_W; p++) send(1'b0, DATA_W'(p));
        idle(2);
        chk("bp_windows", 72'(win_count - c0), 72'd12);
`endif

        // Random frames, gaps, occasional restarts and (if present) random consumer stalls.
        rand_ready = BP;
        for (int f = 0; f < 8; f++) begin
            nrows = $urandom_range(3, 6);
            for (int q = 0; q < IMG_W * nrows; q++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send(q == 0 || $urandom_range(0, 150) == 0, DATA_W'($urandom_range(0, 255)));
            end
        end
        rand_ready = 1'b0;
        win_ready  = 1'b1;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_window_buffer.md
LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 640, pixels per image line; legal range 4..4096.
REQ-003 SHALL have parameter K, default 3, window edge size; legal values 3, 5, 7.
REQ-004 SHALL have port clk  input  1  clock; reset rstN, asynchronous, active-low; clock clk.
REQ-005 SHALL have port rstN  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_sof  input  1  marks the accepted pixel as row 0, column 0 of a frame.
REQ-007 SHALL have port i_data  input  DATA_W  pixel, raster order.
REQ-008 SHALL have port i_data_valid  input  1  pixel qualifier.
REQ-009 SHALL have port o_in_ready  output  1  pixel accepted when i_data_valid && o_in_ready.
REQ-010 SHALL have port o_win  output  K*K*DATA_W  window; element (r,c) at bits [(r*K+c)*DATA_W +: DATA_W]; r=0 oldest row, c=0 leftmost column.
REQ-011 SHALL have port o_win_valid  output  1  o_win qualifier.
REQ-012 SHALL have port o_busy  output  1  high in FILL or RUN state.

Function
REQ-013 SHALL store K-1 full lines in rotating line memories indexed by column counter col (0..IMG_W-1).
REQ-014 SHALL, per accepted pixel at column col, shift window left one column, load new right column = {stored lines at col, oldest first; i_data last}, and overwrite the oldest line's entry at col with i_data.
REQ-015 SHALL increment col per accepted pixel; at col==IMG_W-1 wrap col to 0, rotate line-memory roles, increment row counter, saturating at K-1.
REQ-016 SHALL implement FSM IDLE -> FILL on accepted pixel with i_sof; FILL -> RUN when row reaches K-1; RUN stays until reset or i_sof.
REQ-017 SHALL treat an accepted i_sof in FILL or RUN as frame restart: that pixel is column 0, row 0, state FILL; stored contents not cleared.
REQ-018 SHALL ignore accepted pixels in IDLE without i_sof (no state, counter or memory change).
REQ-019 SHALL assert o_win_valid exactly 1 cycle after an accepted pixel with state RUN (after update) and col >= K-1 at that pixel; no window straddles a line wrap.
REQ-020 SHALL hold o_win unchanged on cycles with no accepted pixel.
REQ-021 SHALL produce no o_win_valid for accepted pixels while in FILL.

Reset
REQ-022 SHALL on rstN low asynchronously set state IDLE, col 0, row 0, o_win_valid 0, o_win all zero, o_busy 0, o_in_ready 1.
REQ-023 SHALL not require line memories to be reset; their contents are undefined until rewritten in FILL.
REQ-024 SHALL, on reset mid-frame, discard the frame; the next valid output requires a new i_sof and K-1 full lines.

Configuration
REQ-025 SHALL support macro LINE_WINDOW_BUFFER_BACKPRESSURE_EN.
REQ-026 SHALL with macro defined add port i_win_ready input 1; o_in_ready = !o_win_valid || i_win_ready; o_win/o_win_valid hold while o_win_valid && !i_win_ready.
REQ-027 SHALL without macro omit i_win_ready, tie o_in_ready to 1, and keep o_win_valid high for one cycle per window.

Verification
REQ-028 SHALL cover: IMG_W=8, K=3, pixel value = row*8+col, i_sof on first -> first o_win_valid 1 cycle after pixel (2,2); o_win rows {0,1,2},{8,9,10},{16,17,18}.
REQ-029 SHALL cover: same stream continued -> exactly 6 windows per line for rows 2..N; none after pixels at col 0 or 1.
REQ-030 SHALL cover: i_sof reasserted at pixel (3,4) -> o_win_valid low until new row 2, col 2; then window built only from post-sof pixels.
REQ-031 SHALL cover: rstN pulsed low mid-RUN -> o_win_valid 0, o_win 0, o_busy 0 same cycle; pixels without i_sof ignored afterwards.
REQ-032 SHALL cover: i_data_valid gaps (1 of 3 cycles) -> identical window sequence to gap-free stream; o_win stable during gaps.
REQ-033 SHALL cover (macro defined): i_win_ready low 5 cycles with window pending -> o_in_ready 0, o_win stable, no window lost or duplicated.
